// File: rtl/line_memory.sv
`default_nettype none
// ============================================================================
// line_memory : dual-port fixed-latency 64-bit line memory behind I/D caches;
//               optional DMA word-write port enabled by LINE_MEMORY_DMA_EN.
// Revision    : 1.0
// ============================================================================
module line_memory #(
  parameter int LINE_AW = 8,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_readM,
  input  logic        i_writeM,
  input  logic [15:0] i_addressM,
  inout  wire  [63:0] i_dataM,
  input  logic        d_readM,
  input  logic        d_writeM,
  input  logic [15:0] d_addressM,
  inout  wire  [63:0] d_dataM,
  output logic        i_busy,
  output logic        d_busy,
  output logic        proto_err
`ifdef LINE_MEMORY_DMA_EN
  ,
  input  logic        dma_writeM,
  input  logic [15:0] dma_addressM,
  input  logic [15:0] dma_dataM,
  output logic        dma_ack
`endif
);

  localparam int         DEPTH    = 1 << LINE_AW;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_DRIVE  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  logic [63:0]        mem_q [DEPTH];

  logic [1:0]         i_state_q, i_state_d;
  logic [2:0]         i_cnt_q, i_cnt_d;
  logic [LINE_AW-1:0] i_line_q, i_line_d;
  logic [63:0]        i_rdata_q, i_rdata_d;

  logic [1:0]         d_state_q, d_state_d;
  logic [2:0]         d_cnt_q, d_cnt_d;
  logic [LINE_AW-1:0] d_line_q, d_line_d;
  logic               d_wr_q, d_wr_d;
  logic [63:0]        d_rdata_q, d_rdata_d;

  logic               perr_q, perr_d;

  logic               i_open, i_accept, d_open, d_req, d_accept;
  logic               i_drive, d_drive;
  logic               wr_en;
  logic [LINE_AW-1:0] wr_line;
  logic [63:0]        wr_data, wr_mask;

  // The final cycle of a transaction already accepts the next request.
  assign i_open   = (i_state_q == S_IDLE) || (i_state_q == S_DRIVE);
  assign i_accept = i_readM && i_open;
  assign d_open   = (d_state_q == S_IDLE) || (d_state_q == S_DRIVE) || (d_state_q == S_COMMIT);
  assign d_req    = d_readM ^ d_writeM;
  assign d_accept = d_req && d_open;

`ifdef LINE_MEMORY_DMA_EN
  logic dma_accept;
  logic dma_ack_q, dma_ack_d;
  logic unused_addr_bits;

  assign dma_accept = dma_writeM && (d_state_q == S_IDLE) && !(d_readM || d_writeM);
  assign dma_ack_d  = dma_accept;
  assign unused_addr_bits = ^{i_addressM[15:LINE_AW+2], i_addressM[1:0],
                              d_addressM[15:LINE_AW+2], d_addressM[1:0],
                              dma_addressM[15:LINE_AW+2]};
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addressM[15:LINE_AW+2], i_addressM[1:0],
                              d_addressM[15:LINE_AW+2], d_addressM[1:0]};
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_state_q <= S_IDLE;
      i_cnt_q   <= '0;
      i_line_q  <= '0;
      i_rdata_q <= '0;
      d_state_q <= S_IDLE;
      d_cnt_q   <= '0;
      d_line_q  <= '0;
      d_wr_q    <= 1'b0;
      d_rdata_q <= '0;
      perr_q    <= 1'b0;
`ifdef LINE_MEMORY_DMA_EN
      dma_ack_q <= 1'b0;
`endif
    end else begin
      i_state_q <= i_state_d;
      i_cnt_q   <= i_cnt_d;
      i_line_q  <= i_line_d;
      i_rdata_q <= i_rdata_d;
      d_state_q <= d_state_d;
      d_cnt_q   <= d_cnt_d;
      d_line_q  <= d_line_d;
      d_wr_q    <= d_wr_d;
      d_rdata_q <= d_rdata_d;
      perr_q    <= perr_d;
`ifdef LINE_MEMORY_DMA_EN
      dma_ack_q <= dma_ack_d;
`endif
    end
  end

  // I-port next state
  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    i_line_d  = i_line_q;
    i_rdata_d = i_rdata_q;
    case (i_state_q)
      S_WAIT: begin
        if (i_cnt_q == 3'd1) begin
          i_state_d = S_DRIVE;
          i_rdata_d = mem_q[i_line_q];
        end else begin
          i_cnt_d = i_cnt_q - 3'd1;
        end
      end
      S_DRIVE: i_state_d = S_IDLE;
      default: ;
    endcase
    if (i_accept) begin
      i_state_d = S_WAIT;
      i_cnt_d   = CNT_INIT;
      i_line_d  = i_addressM[LINE_AW+1:2];
    end
  end

  // D-port next state
  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    d_line_d  = d_line_q;
    d_wr_d    = d_wr_q;
    d_rdata_d = d_rdata_q;
    case (d_state_q)
      S_WAIT: begin
        if (d_cnt_q == 3'd1) begin
          d_state_d = d_wr_q ? S_COMMIT : S_DRIVE;
          if (!d_wr_q) d_rdata_d = mem_q[d_line_q];
        end else begin
          d_cnt_d = d_cnt_q - 3'd1;
        end
      end
      S_DRIVE:  d_state_d = S_IDLE;
      S_COMMIT: d_state_d = S_IDLE;
      default: ;
    endcase
    if (d_accept) begin
      d_state_d = S_WAIT;
      d_cnt_d   = CNT_INIT;
      d_line_d  = d_addressM[LINE_AW+1:2];
      d_wr_d    = d_writeM;
    end
  end

  always_comb begin
    perr_d = perr_q | i_writeM | (i_readM & ~i_open) | (d_readM & d_writeM)
           | ((d_readM | d_writeM) & ~d_open);
  end

  // Array write port: D commit, or a DMA lane write while D is idle.
  always_comb begin
    wr_en   = 1'b0;
    wr_line = d_line_q;
    wr_data = d_dataM;
    wr_mask = '1;
    if (d_state_q == S_COMMIT) begin
      wr_en = 1'b1;
    end
`ifdef LINE_MEMORY_DMA_EN
    else if (dma_accept) begin
      wr_en   = 1'b1;
      wr_line = dma_addressM[LINE_AW+1:2];
      wr_data = {4{dma_dataM}};
      wr_mask = 64'hFFFF << {dma_addressM[1:0], 4'b0000};
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (wr_en) begin
      mem_q[wr_line] <= (mem_q[wr_line] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  // Outputs
  always_comb begin
    i_busy    = (i_state_q != S_IDLE);
    i_drive   = (i_state_q == S_DRIVE);
    d_busy    = (d_state_q != S_IDLE);
    d_drive   = (d_state_q == S_DRIVE);
    proto_err = perr_q;
`ifdef LINE_MEMORY_DMA_EN
    dma_ack   = dma_ack_q;
`endif
  end

  assign i_dataM = i_drive ? i_rdata_q : {64{1'bz}};
  assign d_dataM = d_drive ? d_rdata_q : {64{1'bz}};

endmodule
`default_nettype wire
